// File: rtl/mcycle_sequencer_if.sv
// Handshake bundle between the execute-stage sequencer and the multi-cycle
// multiply/divide unit.
interface mcycle_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             UnitStart;
    logic [1:0]       UnitOp;
    logic [WIDTH-1:0] UnitOperand1;
    logic [WIDTH-1:0] UnitOperand2;
    logic             UnitBusy;
    logic [WIDTH-1:0] UnitResult1;
    logic [WIDTH-1:0] UnitResult2;

    modport master (
        output UnitStart, UnitOp, UnitOperand1, UnitOperand2,
        input  UnitBusy, UnitResult1, UnitResult2
    );

    modport slave (
        input  UnitStart, UnitOp, UnitOperand1, UnitOperand2,
        output UnitBusy, UnitResult1, UnitResult2
    );
endinterface

// File: rtl/mcycle_sequencer.sv
// Launches the MCycle multiply/divide unit for the execute stage, stalls until
// it finishes, and short-circuits repeated operand pairs through a 1-entry cache.
module mcycle_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic             ResultSel,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    mcycle_sequencer_if.master unitBus,
    output logic             Stall,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } stateT;

    stateT            state;
    logic             busyQ;
    logic             unitDone;
    logic             cacheHit;
    logic             cacheWr;
    logic             cacheValid;
    logic             selQ;
    logic             unitStartQ;
    logic [1:0]       unitOpQ;
    logic [WIDTH-1:0] operand1Q;
    logic [WIDTH-1:0] operand2Q;
    logic [CNT_W-1:0] waitCnt;
    logic [1:0]       cacheOp;
    logic [WIDTH-1:0] cacheA;
    logic [WIDTH-1:0] cacheB;
    logic [WIDTH-1:0] cacheR1;
    logic [WIDTH-1:0] cacheR2;

    // The unit signals completion only by dropping Busy, so watch for the fall.
    assign unitDone = busyQ && !unitBus.UnitBusy;
    assign cacheHit = cacheValid && (Op == cacheOp) &&
                      (OperandA == cacheA) && (OperandB == cacheB);
    assign cacheWr  = (state == WAIT) && !Flush && unitDone;

    assign unitBus.UnitStart    = unitStartQ;
    assign unitBus.UnitOp       = unitOpQ;
    assign unitBus.UnitOperand1 = operand1Q;
    assign unitBus.UnitOperand2 = operand2Q;

    always_comb begin
        Stall = 1'b0;
        case (state)
            IDLE:    Stall = Start && !Flush;
            WAIT:    Stall = 1'b1;
            DRAIN:   Stall = Start;
            default: Stall = 1'b0;
        endcase
        if (RESET) Stall = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            busyQ      <= 1'b0;
            cacheValid <= 1'b0;
            selQ       <= 1'b0;
            unitStartQ <= 1'b0;
            unitOpQ    <= '0;
            operand1Q  <= '0;
            operand2Q  <= '0;
            waitCnt    <= '0;
            Result     <= '0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            busyQ      <= unitBus.UnitBusy;
            unitStartQ <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            if (Flush) cacheValid <= 1'b0;

            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        unitOpQ   <= Op;
                        operand1Q <= OperandA;
                        operand2Q <= OperandB;
                        selQ      <= ResultSel;
                        if (cacheHit) begin
                            Result <= ResultSel ? cacheR2 : cacheR1;
                            Done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            unitStartQ <= 1'b1;
                            waitCnt    <= '0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (Flush) begin
                        state <= DRAIN;
                    end else if (unitDone) begin
                        cacheValid <= 1'b1;
                        Result     <= selQ ? unitBus.UnitResult2 : unitBus.UnitResult1;
                        Done       <= 1'b1;
                        state      <= DONE;
                    end else if (waitCnt == CNT_LAST) begin
                        cacheValid <= 1'b0;
                        Result     <= '0;
                        Done       <= 1'b1;
                        Timeout    <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    // The unit cannot abort: let it finish and throw the result away.
                    waitCnt <= waitCnt + 1'b1;
                    if (unitDone || (waitCnt == CNT_LAST)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (cacheWr) begin
            cacheOp <= unitOpQ;
            cacheA  <= operand1Q;
            cacheB  <= operand2Q;
            cacheR1 <= unitBus.UnitResult1;
            cacheR2 <= unitBus.UnitResult2;
        end
    end

endmodule
